// File: rtl/io_input_bank_if.sv
// CPU-side I/O bus for the input-port bank: word-addressed register reads and strobed writes.
interface io_input_bank_if #(
  parameter int unsigned DW = 32
);
  logic [31:0]   addr;
  logic          io_we;
  logic [DW-1:0] io_wdata;
  logic [DW-1:0] io_read_data;

  modport master (
    output addr,
    output io_we,
    output io_wdata,
    input  io_read_data
  );

  modport slave (
    input  addr,
    input  io_we,
    input  io_wdata,
    output io_read_data
  );
endinterface

// File: rtl/io_input_bank.sv
// Memory-mapped bank of synchronised input ports with sticky change flags, W1C status,
// an interrupt mask and a registered interrupt request.
module io_input_bank #(
  parameter int unsigned NPORTS      = 4,
  parameter int unsigned DW          = 32,
  parameter logic [5:0]  BASE_WORD   = 6'h20,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 io_clk,
  input  logic                 resetn,
  io_input_bank_if.slave       bus,
  input  logic [NPORTS*DW-1:0] in_port,
  output logic                 io_irq
);

  localparam int unsigned BaseWord   = 32'(BASE_WORD);
  localparam int unsigned StatusWord = BaseWord + NPORTS;
  localparam int unsigned MaskWord   = BaseWord + NPORTS + 1;
  localparam int unsigned Last       = SYNC_STAGES - 1;

  if (NPORTS < 1 || NPORTS > 16) begin : gen_bad_nports
    $error("io_input_bank: NPORTS must be in 1..16");
  end
  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : gen_bad_sync
    $error("io_input_bank: SYNC_STAGES must be in 1..3");
  end
  if (MaskWord > 63) begin : gen_bad_map
    $error("io_input_bank: register map exceeds the 64-word window");
  end
  if (NPORTS > DW) begin : gen_bad_dw
    $error("io_input_bank: DW must hold one flag bit per port");
  end

  logic [DW-1:0]     sync_q [NPORTS][SYNC_STAGES];
  logic [DW-1:0]     sync_d [NPORTS][SYNC_STAGES];
  logic [NPORTS-1:0] chg_q, chg_d;
  logic [NPORTS-1:0] mask_q, mask_d;
  logic              irq_q, irq_d;
  logic [5:0]        word;
  logic              status_we, mask_we;
  logic [DW-1:0]     rdata;
  logic              unused_bits;

  assign word        = bus.addr[7:2];
  assign status_we   = bus.io_we && (32'(word) == StatusWord);
  assign mask_we     = bus.io_we && (32'(word) == MaskWord);
  assign unused_bits = ^{bus.addr[31:8], bus.addr[1:0], bus.io_wdata};

  always_comb begin
    for (int unsigned i = 0; i < NPORTS; i++) begin
      sync_d[i][0] = in_port[i*DW +: DW];
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_d[i][s] = sync_q[i][s-1];
      end
      // A change landing in dreg wins over a coincident W1C of the same flag.
      chg_d[i] = (sync_d[i][Last] != sync_q[i][Last]) |
                 (chg_q[i] & ~(status_we & bus.io_wdata[i]));
    end
    mask_d = mask_we ? bus.io_wdata[NPORTS-1:0] : mask_q;
    irq_d  = |(chg_q & mask_q);
  end

  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      sync_q <= '{default: '0};
      chg_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      chg_q  <= chg_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NPORTS; i++) begin
      if (32'(word) == BaseWord + i) begin
        rdata = sync_q[i][Last];
      end
    end
    if (32'(word) == StatusWord) begin
      rdata = DW'(chg_q);
    end
    if (32'(word) == MaskWord) begin
      rdata = DW'(mask_q);
    end
  end

  assign bus.io_read_data = rdata;
  assign io_irq           = irq_q;

endmodule
